// File: rtl/dac_bank.sv
// Multi-channel 1-bit audio DAC bank: double-buffered samples, slewed volume,
// and a first-order delta-sigma modulator per channel gated by a volume duty pattern.
module dac_bank #(
    parameter int CHANNELS = 4,
    parameter int DATA_W   = 8,
    parameter int VOL_W    = 6,
    parameter int VOL_STEP = 31,
    parameter int RAMP_DIV = 256,
    localparam int CHN_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int WD_W    = (DATA_W > VOL_W) ? DATA_W : VOL_W
) (
    input  logic                clk32,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic                wr_vol,
    input  logic [CHN_W-1:0]    wr_chn,
    input  logic [WD_W-1:0]     wr_data,
    input  logic                sync_en,
    input  logic                sample_tick,
    output logic [CHANNELS-1:0] dac_out,
    output logic                ramp_busy
);
    localparam int PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [VOL_W-1:0]    vol_cnt_q, vol_cnt_d;
    logic                busy_q, busy_d;
    logic                wrap;
    logic                commit;
    logic [CHANNELS-1:0] mismatch;

    assign wrap      = (pre_q == PRE_W'(RAMP_DIV - 1));
    assign commit    = sync_en && sample_tick;
    assign pre_d     = wrap ? '0 : pre_q + 1'b1;
    assign vol_cnt_d = vol_cnt_q + VOL_W'(VOL_STEP);
    assign busy_d    = |mismatch;

    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) begin
            pre_q     <= '0;
            vol_cnt_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            vol_cnt_q <= vol_cnt_d;
            busy_q    <= busy_d;
        end
    end

    assign ramp_busy = busy_q;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        logic [DATA_W-1:0] pend_q, pend_d, smp_q, smp_d, acc_q, acc_d;
        logic [VOL_W-1:0]  tgt_q, tgt_d, cur_q, cur_d;
        logic              en_q, en_d, tgl_q, tgl_d, mod_q, mod_d, dac_q;
        logic [DATA_W:0]   sum;
        logic              sel, smp_wr, vol_wr;

        // Only in-range channel numbers can match, so writes past CHANNELS fall away.
        assign sel    = wr_en && (wr_chn == CHN_W'(gi));
        assign smp_wr = sel && !wr_vol;
        assign vol_wr = sel && wr_vol;
        assign sum    = {1'b0, acc_q} + {1'b0, smp_q};

        always_comb begin
            pend_d = smp_wr ? wr_data[DATA_W-1:0] : pend_q;
            smp_d  = smp_q;
            if (commit) begin
                smp_d = pend_d;
            end else if (!sync_en && smp_wr) begin
                smp_d = wr_data[DATA_W-1:0];
            end

            tgt_d = vol_wr ? wr_data[VOL_W-1:0] : tgt_q;
            cur_d = cur_q;
            if (wrap && (cur_q < tgt_q)) begin
                cur_d = cur_q + 1'b1;
            end else if (wrap && (cur_q > tgt_q)) begin
                cur_d = cur_q - 1'b1;
            end

            en_d = (vol_cnt_q < cur_q) || (&cur_q);

            // Gated-off cycles emit an alternating pattern, i.e. midscale.
            if (en_q) begin
                acc_d = sum[DATA_W-1:0];
                tgl_d = 1'b0;
                mod_d = sum[DATA_W];
            end else begin
                acc_d = acc_q;
                tgl_d = ~tgl_q;
                mod_d = ~tgl_q;
            end
        end

        always_ff @(posedge clk32 or negedge rst_n) begin
            if (!rst_n) begin
                pend_q <= '0;
                smp_q  <= '0;
                acc_q  <= '0;
                tgt_q  <= '0;
                cur_q  <= '0;
                en_q   <= 1'b0;
                tgl_q  <= 1'b0;
                mod_q  <= 1'b0;
                dac_q  <= 1'b0;
            end else begin
                pend_q <= pend_d;
                smp_q  <= smp_d;
                acc_q  <= acc_d;
                tgt_q  <= tgt_d;
                cur_q  <= cur_d;
                en_q   <= en_d;
                tgl_q  <= tgl_d;
                mod_q  <= mod_d;
                dac_q  <= mod_q;
            end
        end

        assign mismatch[gi] = (cur_q != tgt_q);
        assign dac_out[gi]  = dac_q;
    end

endmodule
